text_line_composer: RTL and testbench

//  Builds the packed character-code bus that the VGA text renderer draws: 12 lines x 9 chars x 7-bit codes.

---
 rtl/text_line_composer.sv | 206 ++++++++++++++++++++
 tb/tb_text_line_composer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_line_composer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | text_line_composer: screen text store (LINES x CHARS x CW) with a cursor,  |
// | driven by valid/ready terminal commands; packs text for the VGA renderer.  |
// | Optional macro SCROLL_EN: line advance past the last line scrolls text up. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module text_line_composer #(
    parameter int            LINES      = 12,
    parameter int            CHARS      = 9,
    parameter int            CW         = 7,
    parameter logic [CW-1:0] BLANK_CODE = 7'h20
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [CW-1:0]             cmd_char,
    output logic [LINES*CHARS*CW-1:0] words,
    output logic [3:0]                cur_line,
    output logic [3:0]                cur_col,
    output logic                      busy
);

    localparam logic [2:0] OP_WRITE   = 3'd0;
    localparam logic [2:0] OP_BKSP    = 3'd1;
    localparam logic [2:0] OP_NEWLINE = 3'd2;
    localparam logic [2:0] OP_CLEAR   = 3'd3;
    localparam logic [2:0] OP_SETLINE = 3'd4;

    localparam logic [3:0] LAST_LINE = 4'(LINES - 1);
    localparam logic [3:0] LAST_COL  = 4'(CHARS - 1);

`ifdef SCROLL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEAR = 2'd1, S_SCROLL = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEAR = 2'd1} state_t;
`endif

    state_t        state_q, state_d;
    logic [3:0]    line_q, line_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    k_q, k_d;
    logic [CW-1:0] scr_q [LINES][CHARS];
    logic [CW-1:0] scr_d [LINES][CHARS];

    logic          adv;
    logic          wr_en;
    logic [3:0]    wr_line;
    logic [3:0]    wr_col;
    logic [CW-1:0] wr_data;

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        col_d   = col_q;
        k_d     = k_q;
        scr_d   = scr_q;
        adv     = 1'b0;
        wr_en   = 1'b0;
        wr_line = line_q;
        wr_col  = col_q;
        wr_data = BLANK_CODE;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            wr_en   = 1'b1;
                            wr_data = cmd_char;
                            if (col_q < LAST_COL) begin
                                col_d = col_q + 4'd1;
                            end else begin
                                col_d = 4'd0;
                                adv   = 1'b1;
                            end
                        end
                        OP_BKSP: begin
                            // The erased cell is the one the cursor moves back onto
                            if (col_q != 4'd0) begin
                                col_d  = col_q - 4'd1;
                                wr_en  = 1'b1;
                                wr_col = col_q - 4'd1;
                            end else if (line_q != 4'd0) begin
                                line_d  = line_q - 4'd1;
                                col_d   = LAST_COL;
                                wr_en   = 1'b1;
                                wr_line = line_q - 4'd1;
                                wr_col  = LAST_COL;
                            end
                        end
                        OP_NEWLINE: begin
                            col_d = 4'd0;
                            adv   = 1'b1;
                        end
                        OP_CLEAR: begin
                            state_d = S_CLEAR;
                            k_d     = 4'd0;
                        end
                        OP_SETLINE: begin
                            if ({1'b0, cmd_char[3:0]} < 5'(LINES)) begin
                                line_d = cmd_char[3:0];
                                col_d  = 4'd0;
                            end
                        end
                        default: ;
                    endcase
                end

                if (adv) begin
                    if (line_q < LAST_LINE) begin
                        line_d = line_q + 4'd1;
                    end else begin
`ifdef SCROLL_EN
                        state_d = S_SCROLL;
                        k_d     = 4'd0;
                        line_d  = LAST_LINE;
                        col_d   = 4'd0;
`else
                        line_d  = 4'd0;
                        col_d   = 4'd0;
`endif
                    end
                end
            end

            S_CLEAR: begin
                for (int l = 0; l < LINES; l++) begin
                    if (4'(l) == k_q) begin
                        for (int c = 0; c < CHARS; c++) scr_d[l][c] = BLANK_CODE;
                    end
                end
                if (k_q == LAST_LINE) begin
                    line_d  = 4'd0;
                    col_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end

`ifdef SCROLL_EN
            S_SCROLL: begin
                for (int l = 0; l < LINES - 1; l++) begin
                    if (4'(l) == k_q) begin
                        for (int c = 0; c < CHARS; c++) scr_d[l][c] = scr_q[l+1][c];
                    end
                end
                if (k_q == LAST_LINE) begin
                    for (int c = 0; c < CHARS; c++) scr_d[LINES-1][c] = BLANK_CODE;
                    state_d = S_IDLE;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase

        // Single-cell writes only originate from IDLE, so they never collide with bulk updates
        if (wr_en) begin
            for (int l = 0; l < LINES; l++) begin
                for (int c = 0; c < CHARS; c++) begin
                    if (4'(l) == wr_line && 4'(c) == wr_col) scr_d[l][c] = wr_data;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            line_q  <= 4'd0;
            col_q   <= 4'd0;
            k_q     <= 4'd0;
            for (int l = 0; l < LINES; l++) begin
                for (int c = 0; c < CHARS; c++) scr_q[l][c] <= BLANK_CODE;
            end
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            col_q   <= col_d;
            k_q     <= k_d;
            scr_q   <= scr_d;
        end
    end

    always_comb begin
        words = '0;
        for (int l = 0; l < LINES; l++) begin
            for (int c = 0; c < CHARS; c++) begin
                words[LINES*CHARS*CW-1-(l*CHARS+c)*CW -: CW] = scr_q[l][c];
            end
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = !cmd_ready;
    assign cur_line  = line_q;
    assign cur_col   = col_q;

endmodule
`default_nettype wire

// File: tb/tb_text_line_composer.sv
`default_nettype none
// Bench for text_line_composer: directed vector table, corner sequences, and
// random commands checked against a linear-position screen model.
module tb_text_line_composer;

    localparam int NL = 12;
    localparam int NC = 9;
    localparam int W  = NL * NC * 7;
    localparam logic [6:0] BLANK = 7'h20;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'd0;
    logic [6:0]   cmd_char = 7'd0;
    logic [W-1:0] words;
    logic [3:0]   cur_line;
    logic [3:0]   cur_col;
    logic         busy;

    text_line_composer dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_char (cmd_char),
        .words    (words),
        .cur_line (cur_line),
        .cur_col  (cur_col),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [6:0] m_scr [NL][NC];
    int m_line, m_col, m_busy;

`ifdef SCROLL_EN
    localparam int WRAP_LINE = NL - 1;
    localparam int WRAP_BUSY = NL;
`else
    localparam int WRAP_LINE = 0;
    localparam int WRAP_BUSY = 0;
`endif

    typedef struct {
        logic [2:0] op;
        logic [6:0] ch;
        int         exp_line;
        int         exp_col;
        int         exp_busy;
    } vec_t;
    vec_t vecs [21];

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < NL; l++)
            for (int c = 0; c < NC; c++) m_scr[l][c] = BLANK;
        m_line = 0;
        m_col  = 0;
        m_busy = 0;
    endtask

    function automatic logic [W-1:0] model_words();
        logic [W-1:0] v;
        v = '0;
        for (int l = 0; l < NL; l++)
            for (int c = 0; c < NC; c++)
                v[W-1-(l*NC+c)*7 -: 7] = m_scr[l][c];
        return v;
    endfunction

    task automatic model_line_advance();
        if (m_line < NL - 1) begin
            m_line++;
        end else begin
`ifdef SCROLL_EN
            for (int l = 0; l < NL - 1; l++) m_scr[l] = m_scr[l+1];
            for (int c = 0; c < NC; c++) m_scr[NL-1][c] = BLANK;
            m_line = NL - 1;
            m_col  = 0;
            m_busy = NL;
`else
            m_line = 0;
            m_col  = 0;
`endif
        end
    endtask

    task automatic model_apply(input logic [2:0] op, input logic [6:0] ch);
        int pos;
        logic [3:0] idx;
        m_busy = 0;
        case (op)
            3'd0: begin
                m_scr[m_line][m_col] = ch;
                if (m_col < NC - 1) m_col++;
                else begin
                    m_col = 0;
                    model_line_advance();
                end
            end
            3'd1: begin
                pos = m_line * NC + m_col;
                if (pos > 0) begin
                    pos--;
                    m_line = pos / NC;
                    m_col  = pos % NC;
                    m_scr[m_line][m_col] = BLANK;
                end
            end
            3'd2: begin
                m_col = 0;
                model_line_advance();
            end
            3'd3: begin
                for (int l = 0; l < NL; l++)
                    for (int c = 0; c < NC; c++) m_scr[l][c] = BLANK;
                m_line = 0;
                m_col  = 0;
                m_busy = NL;
            end
            3'd4: begin
                idx = ch[3:0];
                if (int'(idx) < NL) begin
                    m_line = int'(idx);
                    m_col  = 0;
                end
            end
            default: ;
        endcase
    endtask

    // Present a command, hold it until accepted; returns cycles spent waiting
    task automatic issue(input logic [2:0] op, input logic [6:0] ch, output int waited);
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_char  = ch;
        waited    = 0;
        while (!cmd_ready && waited < 64) begin
            @(negedge CLK);
            waited++;
        end
        if (!cmd_ready) begin
            errors++;
            $display("FAIL accept_timeout: cmd_ready still 0 after %0d cycles, required 1", waited);
        end
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        model_apply(op, ch);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge CLK);
        while (busy && n < 64) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_words"}, words, model_words());
        chk({tag, "_line"}, W'(cur_line), W'(m_line));
        chk({tag, "_col"}, W'(cur_col), W'(m_col));
        chk({tag, "_ready"}, W'({cmd_ready, busy}), W'(2'b10));
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [6:0] ch);
        int w, n;
        issue(op, ch, w);
        wait_idle(n);
        chk({tag, "_busy_cycles"}, W'(n), W'(m_busy));
        check_state(tag);
    endtask

    initial begin
        int w, n;
        logic [W-1:0] snap;
        logic [2:0] rop;
        logic [6:0] rch;
        int r;

        for (int i = 0; i < 10; i++)
            vecs[i] = '{3'd0, 7'h41, (i + 1) / NC, (i + 1) % NC, 0};
        vecs[10] = '{3'd1, 7'h00, 1, 0, 0};
        vecs[11] = '{3'd1, 7'h00, 0, 8, 0};
        vecs[12] = '{3'd4, 7'h05, 5, 0, 0};
        vecs[13] = '{3'd4, 7'h0C, 5, 0, 0};
        vecs[14] = '{3'd2, 7'h00, 6, 0, 0};
        vecs[15] = '{3'd5, 7'h41, 6, 0, 0};
        vecs[16] = '{3'd4, 7'h70, 0, 0, 0};
        vecs[17] = '{3'd1, 7'h00, 0, 0, 0};
        vecs[18] = '{3'd4, 7'h0B, 11, 0, 0};
        vecs[19] = '{3'd0, 7'h42, 11, 1, 0};
        vecs[20] = '{3'd2, 7'h00, WRAP_LINE, 0, WRAP_BUSY};

        model_reset();
        repeat (3) @(negedge CLK);
        check_state("reset");
        RST_N = 1'b1;

        for (int i = 0; i < 21; i++) begin
            snap = words;
            issue(vecs[i].op, vecs[i].ch, w);
            wait_idle(n);
            chk($sformatf("vec%0d_busy", i), W'(n), W'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_line", i), W'(cur_line), W'(vecs[i].exp_line));
            chk($sformatf("vec%0d_col", i), W'(cur_col), W'(vecs[i].exp_col));
            chk($sformatf("vec%0d_words", i), words, model_words());
            if (i == 17) chk("bksp_origin_words_unchanged", words, snap);
`ifndef SCROLL_EN
            if (i == 20) chk("wrap_words_unchanged", words, snap);
`endif
        end
        chk("cell_0_0_is_A", W'(words[W-1 -: 7]), W'(7'h41));
        chk("cell_0_8_blank", W'(words[W-1-8*7 -: 7]), W'(BLANK));

        // Fill nearly the whole screen, then CLEAR with a command held behind it
        run_cmd("home", 3'd4, 7'h00);
        for (int i = 0; i < NL * NC - 1; i++) begin
            issue(3'd0, 7'(7'h30 + i % 40), w);
        end
        wait_idle(n);
        check_state("filled");
        issue(3'd3, 7'h00, w);
        issue(3'd4, 7'h03, w);
        chk("clear_hold_wait", W'(w), W'(NL));
        wait_idle(n);
        check_state("after_clear_setline");

        // Asynchronous reset in the middle of CLEAR
        run_cmd("pre_abort", 3'd0, 7'h55);
        issue(3'd3, 7'h00, w);
        repeat (5) @(negedge CLK);
        chk("abort_busy_before", W'(busy), W'(1'b1));
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        check_state("abort_reset");
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            rch = 7'($urandom_range(0, 127));
            if (r < 55)      rop = 3'd0;
            else if (r < 70) rop = 3'd1;
            else if (r < 80) rop = 3'd2;
            else if (r < 83) rop = 3'd3;
            else if (r < 93) begin
                rop = 3'd4;
                rch = 7'($urandom_range(0, 15));
            end else rop = 3'($urandom_range(5, 7));
            run_cmd($sformatf("rnd%0d", i), rop, rch);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
